// File: rtl/sram_req_ctrl.sv
// Valid/ready request front-end for a MEMS1D_BUFG_*x32 SRAM wrapper: registers the SRAM pins,
// captures Q and returns read data in order through a credit-limited response FIFO.
module sram_req_ctrl #(
    parameter int unsigned AS_W      = 3,
    parameter int unsigned AW_W      = 7,
    parameter int unsigned AC_W      = 2,
    parameter int unsigned ADDR_W    = AS_W + AW_W + AC_W,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned RSP_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  CEN,
    output logic                  RDWEN,
    output logic [AS_W-1:0]       AS,
    output logic [AW_W-1:0]       AW,
    output logic [AC_W-1:0]       AC,
    output logic [DATA_W-1:0]     D,
    output logic [DATA_W-1:0]     BW,
    input  logic [DATA_W-1:0]     Q
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

    logic                 req_accept;
    logic                 rd_accept;
    logic                 push;
    logic                 pop;
    logic [DATA_W-1:0]    bw_exp;

    logic                 cen_q, cen_d;
    logic                 rdwen_q, rdwen_d;
    logic [AS_W-1:0]      as_q, as_d;
    logic [AW_W-1:0]      aw_q, aw_d;
    logic [AC_W-1:0]      ac_q, ac_d;
    logic [DATA_W-1:0]    d_q, d_d;
    logic [DATA_W-1:0]    bw_q, bw_d;

    logic                 s1_q, s1_d;
    logic                 s2_q, s2_d;

    logic [CNT_W-1:0]     credits_q, credits_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]    mem_q [RSP_DEPTH];

    // Writes bypass the credit check; reads need room for their response.
    assign req_ready  = !RST && (req_we || (credits_q < DEPTH_C));
    assign req_accept = req_valid && req_ready;
    assign rd_accept  = req_accept && !req_we;
    assign push       = s2_q;
    assign pop        = rsp_valid && rsp_ready;

    assign rsp_valid  = (count_q != '0);
    assign rsp_rdata  = mem_q[rd_ptr_q];

    assign CEN   = cen_q;
    assign RDWEN = rdwen_q;
    assign AS    = as_q;
    assign AW    = aw_q;
    assign AC    = ac_q;
    assign D     = d_q;
    assign BW    = bw_q;

    always_comb begin
        bw_exp = '0;
        for (int unsigned i = 0; i < BE_W; i++) begin
            bw_exp[i*8 +: 8] = {8{req_be[i]}};
        end
    end

    // Idle cycles deassert the strobes but leave address/data/mask parked.
    always_comb begin
        cen_d   = 1'b1;
        rdwen_d = 1'b1;
        as_d    = as_q;
        aw_d    = aw_q;
        ac_d    = ac_q;
        d_d     = d_q;
        bw_d    = bw_q;
        if (req_accept) begin
            cen_d              = 1'b0;
            rdwen_d            = ~req_we;
            {as_d, aw_d, ac_d} = req_addr;
            d_d                = req_wdata;
            bw_d               = bw_exp;
        end
    end

    always_comb begin
        s1_d = rd_accept;
        s2_d = s1_q;
    end

    always_comb begin
        credits_d = credits_q;
        case ({rd_accept, pop})
            2'b10:   credits_d = credits_q + CNT_W'(1);
            2'b01:   credits_d = credits_q - CNT_W'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cen_q     <= 1'b1;
            rdwen_q   <= 1'b1;
            as_q      <= '0;
            aw_q      <= '0;
            ac_q      <= '0;
            d_q       <= '0;
            bw_q      <= '0;
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            credits_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            cen_q     <= cen_d;
            rdwen_q   <= rdwen_d;
            as_q      <= as_d;
            aw_q      <= aw_d;
            ac_q      <= ac_d;
            d_q       <= d_d;
            bw_q      <= bw_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            credits_q <= credits_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Q returning during reset belongs to a discarded read and must not land in the buffer.
    always_ff @(posedge CLK) begin
        if (!RST && push) begin
            mem_q[wr_ptr_q] <= Q;
        end
    end

endmodule
